// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: op/fn encodings, FSM states, datapath width.
package bru_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_BRANCH = 2'b00,
        OP_JAL    = 2'b01,
        OP_JALR   = 2'b10,
        OP_ILL    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        FN_EQ    = 3'b000,
        FN_NE    = 3'b001,
        FN_GE    = 3'b010,
        FN_LT    = 3'b011,
        FN_GTU   = 3'b100,
        FN_LTU   = 3'b101,
        FN_GEU   = 3'b110,
        FN_NEVER = 3'b111
    } fn_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;
endpackage

// File: rtl/branch_resolve_if.sv
// Issue request, writeback result and fetch redirect channels of the branch resolve unit.
interface branch_resolve_if #(parameter int XLEN = bru_pkg::XLEN);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [2:0]      in_fn;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;

    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic            out_mispredict;
    logic            out_misalign;
    logic            out_illegal;
    logic [XLEN-1:0] out_link;

    logic            redir_valid;
    logic            redir_ready;
    logic [XLEN-1:0] redir_pc;

    modport slave (
        input  in_valid, in_op, in_fn, in_pc, in_rs1, in_rs2, in_imm, in_pred_taken,
        output in_ready,
        output out_valid, out_taken, out_mispredict, out_misalign, out_illegal, out_link,
        input  out_ready,
        output redir_valid, redir_pc,
        input  redir_ready
    );

    modport master (
        output in_valid, in_op, in_fn, in_pc, in_rs1, in_rs2, in_imm, in_pred_taken,
        input  in_ready,
        input  out_valid, out_taken, out_mispredict, out_misalign, out_illegal, out_link,
        output out_ready,
        input  redir_valid, redir_pc,
        output redir_ready
    );
endinterface

// File: rtl/bru_cond.sv
// Branch condition evaluator on the compare-datapath 3-bit condition code.
module bru_cond
    import bru_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] rs1_i,
    input  logic [W-1:0] rs2_i,
    input  fn_e          fn_i,
    output logic         cond_o
);
    always_comb begin
        cond_o = 1'b0;
        case (fn_i)
            FN_EQ:    cond_o = (rs1_i == rs2_i);
            FN_NE:    cond_o = (rs1_i != rs2_i);
            FN_GE:    cond_o = ($signed(rs1_i) >= $signed(rs2_i));
            FN_LT:    cond_o = ($signed(rs1_i) <  $signed(rs2_i));
            FN_GTU:   cond_o = (rs1_i >  rs2_i);
            FN_LTU:   cond_o = (rs1_i <  rs2_i);
            FN_GEU:   cond_o = (rs1_i >= rs2_i);
            default:  cond_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve.sv
// Branch/jump resolution: captures one op, reports result to writeback and redirects fetch.
// Optional BRU_STATS_EN adds branch and redirect event counters.
module branch_resolve
    import bru_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    branch_resolve_if.slave   bus
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);
    state_e          state_q, state_d;
    op_e             op_q;
    fn_e             fn_q;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
    logic            pred_q;
    logic            out_done_q, out_done_d;
    logic            redir_done_q, redir_done_d;

    logic            accept, resp;
    logic            cond_c, taken_c, illegal_c, misalign_c, mispred_c;
    logic [XLEN-1:0] link_c, target_c, jalr_sum;
    logic            out_hs, redir_hs, out_fin, redir_fin;

    assign resp   = (state_q == S_RESP);
    assign accept = (state_q == S_IDLE) && bus.in_valid && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_BRANCH;
            fn_q   <= FN_EQ;
            pc_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            imm_q  <= '0;
            pred_q <= 1'b0;
        end else if (accept) begin
            op_q   <= op_e'(bus.in_op);
            fn_q   <= fn_e'(bus.in_fn);
            pc_q   <= bus.in_pc;
            rs1_q  <= bus.in_rs1;
            rs2_q  <= bus.in_rs2;
            imm_q  <= bus.in_imm;
            pred_q <= bus.in_pred_taken;
        end
    end

    bru_cond #(.W(XLEN)) u_cond (
        .rs1_i  (rs1_q),
        .rs2_i  (rs2_q),
        .fn_i   (fn_q),
        .cond_o (cond_c)
    );

    assign illegal_c  = (op_q == OP_ILL);
    assign taken_c    = (op_q == OP_BRANCH) ? cond_c : !illegal_c;
    assign jalr_sum   = rs1_q + imm_q;
    assign target_c   = (op_q == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_q + imm_q;
    assign link_c     = pc_q + XLEN'(4);
    // Misaligned targets go to the trap path, so they never redirect fetch.
    assign misalign_c = taken_c && target_c[1];
    assign mispred_c  = !misalign_c && !illegal_c &&
                        ((taken_c != pred_q) || (op_q == OP_JALR));

    // Data outputs are gated by RESP so idle/reset values read as zero.
    assign bus.in_ready       = (state_q == S_IDLE) && !flush;
    assign bus.out_valid      = resp && !out_done_q;
    assign bus.redir_valid    = resp && mispred_c && !redir_done_q;
    assign bus.out_taken      = resp && taken_c;
    assign bus.out_mispredict = resp && mispred_c;
    assign bus.out_misalign   = resp && misalign_c;
    assign bus.out_illegal    = resp && illegal_c;
    assign bus.out_link       = resp ? link_c : '0;
    assign bus.redir_pc       = resp ? (taken_c ? target_c : link_c) : '0;

    assign out_hs    = bus.out_valid && bus.out_ready;
    assign redir_hs  = bus.redir_valid && bus.redir_ready;
    assign out_fin   = out_done_q || out_hs;
    assign redir_fin = !mispred_c || redir_done_q || redir_hs;

    always_comb begin
        state_d      = state_q;
        out_done_d   = out_done_q;
        redir_done_d = redir_done_q;
        case (state_q)
            S_IDLE: begin
                out_done_d   = 1'b0;
                redir_done_d = 1'b0;
                if (accept) state_d = S_RESP;
            end
            S_RESP: begin
                if (flush || (out_fin && redir_fin)) begin
                    state_d      = S_IDLE;
                    out_done_d   = 1'b0;
                    redir_done_d = 1'b0;
                end else begin
                    out_done_d   = out_fin;
                    redir_done_d = redir_done_q || redir_hs;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            out_done_q   <= 1'b0;
            redir_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_done_q   <= out_done_d;
            redir_done_q <= redir_done_d;
        end
    end

`ifdef BRU_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (out_hs && (op_q == OP_BRANCH)) stat_br_q <= stat_br_q + 32'd1;
            if (redir_hs)                      stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected results queued at issue, checked at handshakes.
module tb_branch_resolve;
    logic clk;
    logic rst_n;
    logic flush;

    branch_resolve_if bif ();

`ifdef BRU_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
    int unsigned exp_br, exp_mp;
`endif

    branch_resolve dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bif)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        taken, mis, mal, ill, is_br;
        logic [31:0] link, rpc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t model(input logic [1:0] op, input logic [2:0] fn,
                                   input logic [31:0] pc, rs1, rs2, imm, input logic pred);
        exp_t e;
        logic c;
        logic [31:0] tgt;
        case (fn)
            3'd0: c = (rs1 == rs2);
            3'd1: c = (rs1 != rs2);
            3'd2: c = !($signed(rs1) < $signed(rs2));
            3'd3: c = ($signed(rs1) < $signed(rs2));
            3'd4: c = (rs2 < rs1);
            3'd5: c = (rs1 < rs2);
            3'd6: c = !(rs1 < rs2);
            default: c = 1'b0;
        endcase
        e.ill   = (op == 2'b11);
        e.is_br = (op == 2'b00);
        e.taken = e.is_br ? c : !e.ill;
        tgt     = (op == 2'b10) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        e.mal   = e.taken && tgt[1];
        e.mis   = !e.mal && !e.ill && ((e.taken != pred) || (op == 2'b10));
        e.link  = pc + 32'd4;
        e.rpc   = e.taken ? tgt : e.link;
        return e;
    endfunction

    task automatic issue_op(input string name, input logic [1:0] op, input logic [2:0] fn,
                            input logic [31:0] pc, rs1, rs2, imm, input logic pred);
        @(negedge clk);
        bif.in_op = op; bif.in_fn = fn; bif.in_pc = pc;
        bif.in_rs1 = rs1; bif.in_rs2 = rs2; bif.in_imm = imm; bif.in_pred_taken = pred;
        bif.in_valid = 1'b1;
        #1;
        checks++;
        if (bif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready: got %b want 1", name, bif.in_ready);
        end
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        sbq.push_back(model(op, fn, pc, rs1, rs2, imm, pred));
    endtask

    // od/rd: cycles after capture before out_ready/redir_ready rise
    task automatic drain_op(input string name, input int od, input int rd);
        exp_t e;
        bit og = 0, rg = 0;
        int c = 0;
        if (sbq.size() == 0) begin
            errors++; checks++;
            $display("FAIL %s scoreboard: got empty want entry", name);
            return;
        end
        e = sbq[0];
        while (!(og && (rg || !e.mis)) && c < 30) begin
            @(negedge clk);
            bif.out_ready   = (c >= od);
            bif.redir_ready = (c >= rd);
            #1;
            if (!og) begin
                checks++;
                if ({bif.out_valid, bif.out_taken, bif.out_mispredict, bif.out_misalign,
                     bif.out_illegal, bif.out_link} !== {1'b1, e.taken, e.mis, e.mal, e.ill, e.link}) begin
                    errors++;
                    $display("FAIL %s result c=%0d: got v=%b t=%b m=%b a=%b i=%b link=%h want v=1 t=%b m=%b a=%b i=%b link=%h",
                             name, c, bif.out_valid, bif.out_taken, bif.out_mispredict, bif.out_misalign,
                             bif.out_illegal, bif.out_link, e.taken, e.mis, e.mal, e.ill, e.link);
                end
            end
            if (!rg) begin
                checks++;
                if (bif.redir_valid !== e.mis) begin
                    errors++;
                    $display("FAIL %s redir_valid c=%0d: got %b want %b", name, c, bif.redir_valid, e.mis);
                end
                if (e.mis) begin
                    checks++;
                    if (bif.redir_pc !== e.rpc) begin
                        errors++;
                        $display("FAIL %s redir_pc: got %h want %h", name, bif.redir_pc, e.rpc);
                    end
                end
            end
            if (!og && bif.out_valid && bif.out_ready) begin
                og = 1;
                void'(sbq.pop_front());
`ifdef BRU_STATS_EN
                if (e.is_br) exp_br++;
`endif
            end
            if (!rg && e.mis && bif.redir_valid && bif.redir_ready) begin
                rg = 1;
`ifdef BRU_STATS_EN
                exp_mp++;
`endif
            end
            c++;
        end
        if (c >= 30) begin
            errors++; checks++;
            $display("FAIL %s timeout: got no completion want completion", name);
        end
        @(negedge clk);
        bif.out_ready = 1'b0; bif.redir_ready = 1'b0;
        #1;
        checks++;
        if ({bif.in_ready, bif.out_valid, bif.redir_valid} !== 3'b100) begin
            errors++;
            $display("FAIL %s idle: got rdy/ov/rv=%b%b%b want 100", name,
                     bif.in_ready, bif.out_valid, bif.redir_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0;
        bif.in_valid = 0; bif.in_op = 0; bif.in_fn = 0; bif.in_pc = 0; bif.in_rs1 = 0;
        bif.in_rs2 = 0; bif.in_imm = 0; bif.in_pred_taken = 0; bif.out_ready = 0; bif.redir_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bif.in_ready, bif.out_valid, bif.redir_valid, bif.out_taken, bif.out_mispredict,
             bif.out_misalign, bif.out_illegal} !== 7'b1000000 || bif.out_link !== 0 || bif.redir_pc !== 0) begin
            errors++;
            $display("FAIL reset: got rdy=%b ov=%b rv=%b flags=%b%b%b%b link=%h rpc=%h want rdy=1 rest 0",
                     bif.in_ready, bif.out_valid, bif.redir_valid, bif.out_taken, bif.out_mispredict,
                     bif.out_misalign, bif.out_illegal, bif.out_link, bif.redir_pc);
        end
`ifdef BRU_STATS_EN
        exp_br = 0; exp_mp = 0;
        checks++;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            errors++;
            $display("FAIL reset stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
        end
`endif
    endtask

    task automatic test_branches;
        issue_op("beq", 2'b00, 3'd0, 32'h8000_0000, 32'd5, 32'd5, 32'h10, 1'b0);
        checks++;
        if (sbq[0].rpc !== 32'h8000_0010 || sbq[0].link !== 32'h8000_0004 || sbq[0].mis !== 1'b1) begin
            errors++;
            $display("FAIL beq model: got rpc=%h link=%h want 80000010/80000004", sbq[0].rpc, sbq[0].link);
        end
        drain_op("beq", 0, 0);
        issue_op("blt", 2'b00, 3'd3, 32'h0000_1000, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
        drain_op("blt", 0, 0);
        issue_op("bltu", 2'b00, 3'd5, 32'h0000_1000, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
        drain_op("bltu", 1, 0);
        issue_op("never", 2'b00, 3'd7, 32'h0000_2000, 32'd1, 32'd1, 32'h8, 1'b0);
        drain_op("never", 0, 0);
        issue_op("illegal", 2'b11, 3'd0, 32'h0000_3000, 32'd0, 32'd0, 32'h8, 1'b1);
        drain_op("illegal", 0, 0);
    endtask

    task automatic test_jumps;
        issue_op("jalr_mal", 2'b10, 3'd0, 32'h0000_4000, 32'h8000_0103, 32'd0, 32'd0, 1'b1);
        drain_op("jalr_mal", 0, 0);
        issue_op("jalr", 2'b10, 3'd0, 32'h0000_4000, 32'h8000_0101, 32'd0, 32'h7, 1'b1);
        drain_op("jalr", 0, 2);
        issue_op("jal_wrap", 2'b01, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 1'b1);
        drain_op("jal_wrap", 0, 0);
        issue_op("jal_mispred", 2'b01, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 1'b0);
        drain_op("jal_mispred", 2, 0);
    endtask

    task automatic test_backpressure;
        issue_op("bp_redir_first", 2'b00, 3'd1, 32'h0000_5000, 32'd1, 32'd2, 32'h20, 1'b0);
        drain_op("bp_redir_first", 3, 0);
        issue_op("bp_out_first", 2'b00, 3'd2, 32'h0000_6000, 32'd2, 32'hFFFF_FFFE, 32'h24, 1'b0);
        drain_op("bp_out_first", 0, 3);
    endtask

    task automatic test_flush;
        issue_op("flush_resp", 2'b00, 3'd0, 32'h0000_7000, 32'd9, 32'd9, 32'h30, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        void'(sbq.pop_front());
        checks++;
        if ({bif.in_ready, bif.out_valid, bif.redir_valid} !== 3'b100) begin
            errors++;
            $display("FAIL flush_resp: got rdy/ov/rv=%b%b%b want 100", bif.in_ready, bif.out_valid, bif.redir_valid);
        end
        @(negedge clk);
        bif.in_valid = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (bif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle ready: got %b want 0", bif.in_ready);
        end
        @(negedge clk);
        bif.in_valid = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if ({bif.in_ready, bif.out_valid, bif.redir_valid} !== 3'b100) begin
            errors++;
            $display("FAIL flush_idle accept: got rdy/ov/rv=%b%b%b want 100", bif.in_ready, bif.out_valid, bif.redir_valid);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            issue_op("random", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC,
                     a, b, $urandom, 1'($urandom_range(0, 1)));
            drain_op("random", $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

`ifdef BRU_STATS_EN
    task automatic test_stats;
        checks++;
        if (stat_branches !== exp_br || stat_mispredicts !== exp_mp) begin
            errors++;
            $display("FAIL stats: got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts, exp_br, exp_mp);
        end
    endtask
`endif

    task automatic test_reset_mid_resp;
        issue_op("rst_mid", 2'b01, 3'd0, 32'h0000_8000, 32'd0, 32'd0, 32'h40, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sbq.pop_front());
        checks++;
        if ({bif.out_valid, bif.redir_valid, bif.out_taken} !== 3'b000 || bif.out_link !== 0) begin
            errors++;
            $display("FAIL rst_mid: got ov=%b rv=%b t=%b link=%h want 0", bif.out_valid, bif.redir_valid,
                     bif.out_taken, bif.out_link);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid ready: got %b want 1", bif.in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_branches();
        test_jumps();
        test_backpressure();
        test_flush();
        test_random();
`ifdef BRU_STATS_EN
        test_stats();
`endif
        test_reset_mid_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Resolves branches and jumps in the NPC execute path. Accepts one control-transfer op per handshake, evaluates the branch condition on the 3-bit comparison code used by the compare datapath, computes target and link address, and drives a redirect request to fetch on misprediction. Sits between issue (upstream) and both writeback (result channel) and fetch (redirect channel).

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous cancel of any held op
- in_valid / in_ready  in / out  1  request handshake
- in_op  in  2  00 BRANCH, 01 JAL, 10 JALR, 11 illegal
- in_fn  in  3  condition: 000 EQ, 001 NE, 010 GE, 011 LT, 100 GTU, 101 LTU, 110 GEU, 111 never
- in_pc, in_rs1, in_rs2, in_imm  in  XLEN  operands
- in_pred_taken  in  1  fetch prediction
- out_valid / out_ready  out / in  1  result handshake
- out_taken, out_mispredict, out_misalign, out_illegal  out  1  result flags
- out_link  out  XLEN  pc+4
- redir_valid / redir_ready  out / in  1  redirect handshake
- redir_pc  out  XLEN  corrected fetch PC

## Operation
- States: IDLE, RESP. in_ready = (state==IDLE) && !flush.
- Accept (in_valid && in_ready): capture all inputs into regs; go RESP.
- Condition from captured rs1/rs2: signed for GE/LT, unsigned for GTU/LTU/GEU; 111 → 0.
- taken: BRANCH → condition; JAL/JALR → 1; illegal op → 0, out_illegal=1.
- target: BRANCH/JAL → pc+imm; JALR → (rs1+imm) & ~1. All adds modulo 2^XLEN, wrap silently.
- out_misalign = taken && target[1]. No redirect when misaligned (trap path handles it).
- out_mispredict = !misalign && !illegal && (taken != pred_taken || op==JALR).
- redir_pc = taken ? target : pc+4.
- In RESP: out_valid=1 until accepted; redir_valid=1 iff mispredict, until accepted. Two done bits track each channel independently; either may complete first or both in same cycle. Return to IDLE at the edge where the last outstanding channel completes.
- flush: next edge → IDLE, done bits cleared, no valid asserted afterward; flush same cycle as in_valid → op not accepted.

## Timing
- Reset: state IDLE, in_ready=1 after reset release, out_valid=0, redir_valid=0, all data/flag outputs 0.
- Latency: accept at edge N → out_valid/redir_valid high in cycle N+1; all outputs registered-input, combinational from capture regs only.
- Min throughput: one op per 2 cycles (no accept in RESP).
- Outputs stable while valid && !ready.
- Reset mid-RESP: immediate return to reset values, op lost.

## Configuration
- BRU_STATS_EN defined: extra outputs stat_branches, stat_mispredicts (32-bit each); +1 on result handshake for op BRANCH, resp. on redirect handshake; wrap at 2^32; reset 0; not cleared by flush.
- Undefined: ports and counters absent; no other behavioural difference.

## Structure
- Package bru_pkg: op codes, fn codes, state enum, XLEN default.
- Sub-module bru_cond: combinational condition evaluator (rs1, rs2, fn → cond).

## Test plan
- BEQ rs1=5, rs2=5, pc=0x8000_0000, imm=0x10, pred 0 → taken=1, mispredict=1, redir_pc=0x8000_0010, out_link=0x8000_0004.
- BLT rs1=0xFFFF_FFFF, rs2=1, pred 1 → taken=1, no redir_valid; same with BLTU → taken=0, redir_pc=pc+4.
- JALR rs1=0x8000_0103, imm=0 → target 0x8000_0102, misalign=1, no redirect.
- Redirect accepted cycle N+1, out_ready held low 3 cycles → out_valid held with stable data, IDLE one edge after out accept, in_ready high.
- flush asserted in RESP with both channels pending → both valids low next cycle; flush with in_valid in IDLE → no accept.
- JAL pc=0xFFFF_FFFC imm=8 → target 0x0000_0004 (wrap); BRU_STATS_EN build: 3 BRANCH ops, 2 redirects → counters 3 and 2.
